// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-path types and constants: instruction/PC widths, fetch FSM
// states, queue entry layout and the PC range check used by the fetch unit.
package rv32i_pkg;
  localparam int ILEN                 = 32;
  localparam int PC_WIDTH             = 32;
  localparam int INSTR_MEM_ADDR_WIDTH = 12;
  localparam logic [PC_WIDTH-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0]     instr;
    logic [PC_WIDTH-1:0] pc;
  } fetch_entry_t;

  // True when any PC bit above the instruction-memory byte range is set.
  function automatic logic pc_out_of_range(input logic [PC_WIDTH-1:0] pc, input int aw);
    return (pc >> (aw + 2)) != '0;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Two-entry flow-through FIFO of fetch entries; an empty queue presents the
// entry being pushed so returning data reaches decode in the same cycle.
module fetch_queue
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_valid,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);
  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_valid = (r_count != 2'd0) || i_push;
  assign w_pop   = i_pop && o_valid;
  assign w_push  = i_push && !i_flush;
  assign o_count = r_count;

  always_comb begin
    o_head = '0;
    if (r_count != 2'd0) o_head = r_mem[r_rd_ptr];
    else if (i_push)     o_head = i_push_data;
  end

  // A bypassed push that is popped at once still walks both pointers, count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && r_count == 2'd2));
endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues 1-cycle-latency imem reads,
// buffers returns for decode, handles redirects and sticky fetch faults.
// Define IFETCH_CTRL_PERF_EN to add perf_fetched/perf_stall/perf_flush counters.
module ifetch_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  IMEM_AW  = INSTR_MEM_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [ILEN-1:0]     imem_rdata,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [ILEN-1:0]     if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                fault,
  output logic [PC_WIDTH-1:0] fault_pc
`ifdef IFETCH_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall,
  output logic [31:0]         perf_flush
`endif
);
  fetch_state_e        r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, r_req_pc, r_fault_pc;
  logic                r_inflight, r_fault;
  logic                w_req, w_pop, w_q_valid, w_pc_oor, w_redir_bad, w_fault_set;
  logic [1:0]          w_q_count;
  logic [2:0]          w_occ;
  fetch_entry_t        w_head, w_push_data;

  assign w_push_data = '{instr: imem_rdata, pc: r_req_pc};

  fetch_queue u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (if_ready),
    .i_flush     (redirect_valid),
    .o_valid     (w_q_valid),
    .o_head      (w_head),
    .o_count     (w_q_count)
  );

  assign if_valid    = w_q_valid;
  assign if_instr    = w_head.instr;
  assign if_pc       = w_head.pc;
  assign w_pop       = w_q_valid && if_ready;
  // Entries owed to decode after this cycle's pop; the in-flight read holds a slot.
  assign w_occ       = {1'b0, w_q_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_pc_oor    = pc_out_of_range(r_pc, IMEM_AW);
  assign w_redir_bad = (redirect_pc[1:0] != 2'b00) || pc_out_of_range(redirect_pc, IMEM_AW);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_fault_set = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (w_pc_oor) begin
          w_state_nxt = FAULT;
          w_fault_set = 1'b1;
        end else if (w_occ < 3'd2) begin
          w_req = 1'b1;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    if (redirect_valid) begin
      w_req       = 1'b0;
      w_fault_set = 1'b0;
      w_state_nxt = w_redir_bad ? FAULT : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_req;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_req) begin
        r_pc     <= r_pc + PC_INCR;
        r_req_pc <= r_pc;
      end
      if (redirect_valid) begin
        r_fault <= w_redir_bad;
        if (w_redir_bad) r_fault_pc <= redirect_pc;
      end else if (w_fault_set) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_pc;
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_req ? r_pc[IMEM_AW+1:2] : '0;
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

`ifdef IFETCH_CTRL_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stall, r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
      r_perf_flush   <= '0;
    end else begin
      if (w_pop)                           r_perf_fetched <= r_perf_fetched + 32'd1;
      if (if_valid && !if_ready)           r_perf_stall   <= r_perf_stall + 32'd1;
      if (redirect_valid && w_occ != 3'd0) r_perf_flush   <= r_perf_flush + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
  assign perf_flush   = r_perf_flush;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus random ready/redirect
// traffic checked against a stream-level model (issue PC, delivery PC, memory image).
module tb_ifetch_ctrl;
  import rv32i_pkg::*;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef IFETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

  ifetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fault(fault), .fault_pc(fault_pc)
`ifdef IFETCH_CTRL_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

  int total = 0;
  int bad   = 0;

  logic        s_req, s_valid, s_fault;
  logic [11:0] s_addr;
  logic [31:0] s_instr, s_pc, s_fault_pc;

  // Stream model: next PC to be requested, next PC owed to decode.
  logic [31:0] m_issue, m_deliver, m_hold_instr, m_hold_pc;
  logic        m_hold;
  int          m_quiet, m_idle, m_fetched, m_stall, m_flush;

  function automatic logic legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && ((pc >> (AW + 2)) == 32'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_issue = 32'h0; m_deliver = 32'h0; m_hold = 1'b0;
    m_quiet = 0; m_idle = 0; m_fetched = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic cyc();
    logic        hs, chg;
    logic [31:0] outst;
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid; s_instr = if_instr;
    s_pc = if_pc; s_fault = fault; s_fault_pc = fault_pc;
    hs  = s_valid && if_ready;
    chg = 1'b0;
    if (m_hold) begin
      chk("hold_valid", 32'(s_valid), 32'd1);
      chk("hold_instr", s_instr, m_hold_instr);
      chk("hold_pc", s_pc, m_hold_pc);
    end
    if (hs) begin
      chk("deliver_pc", s_pc, m_deliver);
      chk("deliver_instr", s_instr, mem[m_deliver[13:2]]);
      chk("deliver_legal", 32'(legal(m_deliver)), 32'd1);
      m_deliver += 32'd4;
      m_fetched++;
    end
    if (s_valid && !if_ready) m_stall++;
    outst = (m_issue - m_deliver) >> 2;
    if (s_req) begin
      chk("req_addr", 32'(s_addr), 32'(m_issue[13:2]));
      chk("req_legal", 32'(legal(m_issue)), 32'd1);
      chk("req_occ", 32'(outst < 32'd2), 32'd1);
      chk("req_redir", 32'(redirect_valid), 32'd0);
      m_issue += 32'd4;
      chg = 1'b1;
    end
    if (!legal(m_issue)) begin
      if (m_quiet >= 2) begin
        chk("fault_set", 32'(s_fault), 32'd1);
        chk("fault_pc", s_fault_pc, m_issue);
      end
    end else begin
      chk("fault_clear", 32'(s_fault), 32'd0);
    end
    if (redirect_valid) begin
      if (outst != 32'd0) m_flush++;
      m_issue = redirect_pc; m_deliver = redirect_pc; chg = 1'b1;
    end
    m_quiet = chg ? 0 : m_quiet + 1;
    if (hs || redirect_valid || !if_ready || !legal(m_issue)) m_idle = 0;
    else m_idle++;
    chk("live", 32'(m_idle <= 4), 32'd1);
    m_hold = s_valid && !if_ready && !redirect_valid;
    m_hold_instr = s_instr; m_hold_pc = s_pc;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_target();
    int          r = $urandom_range(0, 9);
    logic [31:0] w = 32'($urandom_range(0, 4095));
    if (r <= 5) return w << 2;
    if (r == 6) return (w << 2) | 32'($urandom_range(1, 3));
    if (r == 7) return 32'h3FF0 + (32'($urandom_range(0, 3)) << 2);
    if (r == 8) return 32'h0001_0000 + (w << 2);
    return 32'hFFFF_FFFC;
  endfunction

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = ($urandom() << 12) | 32'(k);
    rst_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Boot sequence and back-to-back delivery.
    cyc(); chk("boot_noreq", 32'(s_req), 32'd0);
    cyc(); chk("first_req", 32'(s_req), 32'd1); chk("first_addr", 32'(s_addr), 32'd0);
    chk("first_novalid", 32'(s_valid), 32'd0);
    cyc(); chk("d0_valid", 32'(s_valid), 32'd1); chk("d0_pc", s_pc, 32'h0); chk("d0_addr", 32'(s_addr), 32'd1);
    cyc(); chk("d1_pc", s_pc, 32'h4);
    cyc(); chk("d2_pc", s_pc, 32'h8);

    // Backpressure: requests stop once two entries are owed.
    if_ready = 1'b0;
    repeat (5) cyc();
    chk("stall_noreq", 32'(s_req), 32'd0);
    if_ready = 1'b1;
    repeat (6) cyc();

    // Redirect with a full queue.
    if_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc(); chk("redir_noreq", 32'(s_req), 32'd0);
    redirect_valid = 1'b0; if_ready = 1'b1;
    cyc(); chk("redir_req", 32'(s_req), 32'd1); chk("redir_addr", 32'(s_addr), 32'h40);
    chk("redir_flushed", 32'(s_valid), 32'd0);
    cyc(); chk("redir_valid", 32'(s_valid), 32'd1); chk("redir_pc", s_pc, 32'h100);
    chk("redir_instr", s_instr, mem[12'h40]);
    repeat (3) cyc();

    // Redirect with a read in flight: stale return must be dropped.
    if_ready = 1'b0;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0; if_ready = 1'b1;
    cyc(); chk("stale_dropped", 32'(s_valid), 32'd0);
    cyc(); chk("stale_next_pc", s_pc, 32'h200);

    // Misaligned redirect, then recovery.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    cyc(); chk("mis_fault", 32'(s_fault), 32'd1); chk("mis_fault_pc", s_fault_pc, 32'h102);
    chk("mis_noreq", 32'(s_req), 32'd0);
    repeat (3) cyc();
    chk("mis_still_noreq", 32'(s_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    cyc();
    redirect_valid = 1'b0;
    cyc(); chk("rec_fault", 32'(s_fault), 32'd0); chk("rec_addr", 32'(s_addr), 32'd2);
    cyc(); chk("rec_pc", s_pc, 32'h8);

    // Sequential run-off past the end of instruction memory.
    redirect_valid = 1'b1; redirect_pc = 32'h3FF8;
    cyc();
    redirect_valid = 1'b0;
    cyc(); cyc();
    chk("end_pc0", s_pc, 32'h3FF8);
    cyc(); chk("end_pc1", s_pc, 32'h3FFC);
    repeat (2) cyc();
    chk("end_fault", 32'(s_fault), 32'd1); chk("end_fault_pc", s_fault_pc, 32'h4000);
    chk("end_noreq", 32'(s_req), 32'd0); chk("end_novalid", 32'(s_valid), 32'd0);

    // Random ready/redirect traffic.
    for (int i = 0; i < 3000; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = pick_target();
      cyc();
    end
    redirect_valid = 1'b0;
`ifdef IFETCH_CTRL_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_stall", perf_stall, 32'(m_stall));
    chk("perf_flush", perf_flush, 32'(m_flush));
`endif

    // Asynchronous reset while streaming.
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_instr", if_instr, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_fault", 32'(fault), 32'd0);
`ifdef IFETCH_CTRL_PERF_EN
    chk("arst_perf_fetched", perf_fetched, 32'd0);
    chk("arst_perf_stall", perf_stall, 32'd0);
    chk("arst_perf_flush", perf_flush, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cyc();
    cyc(); chk("restart_req", 32'(s_req), 32'd1); chk("restart_addr", 32'(s_addr), 32'd0);
    cyc(); chk("restart_pc", s_pc, 32'h0);
    repeat (5) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
